// File: rtl/usb_wire_tx_serializer.sv
// ---------------------------------------------------------------------------
// usb_wire_tx_serializer
//
// Transmit-side wire serializer for the USB serial interface engine. The SIE
// transmitter writes 2-bit line states plus a drive-enable flag into a
// 4-entry FIFO. One entry is placed on the differential pad outputs per USB
// bit period, at either the full-speed or the low-speed rate. The block also
// produces TxWireActiveDrive, which the receive path uses to blank its edge
// detection and timeout logic while (and shortly after) we drive the wire.
//
// Ports:
//   clk               in   system clock (48 MHz)
//   rst               in   synchronous, active-high reset
//   TxBitsIn[1:0]     in   line state to transmit, {D+, D-}
//   TxCtrlIn          in   1 = drive wire with TxBitsIn, 0 = release wire
//   SIETxWEn          in   write strobe from the SIE transmitter
//   SIETxRdy          out  FIFO can accept a write this cycle
//   fullSpeedRate     in   1 = full-speed bit rate, 0 = low-speed bit rate
//   TxBitsOut[1:0]    out  line state to pads
//   TxCtrlOut         out  pad output enable
//   TxWireActiveDrive out  transmitter active, for receive-path blanking
//   TxDataOutTick     out  toggles once per transmitted bit period
// ---------------------------------------------------------------------------
module usb_wire_tx_serializer #(
    parameter int FS_DIV    = 4,
    parameter int LS_DIV    = 32,
    parameter int HOLD_BITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] TxBitsIn,
    input  logic       TxCtrlIn,
    input  logic       SIETxWEn,
    output logic       SIETxRdy,
    input  logic       fullSpeedRate,
    output logic [1:0] TxBitsOut,
    output logic       TxCtrlOut,
    output logic       TxWireActiveDrive,
    output logic       TxDataOutTick
);

    localparam logic [4:0] FS_LAST     = 5'(FS_DIV - 1);
    localparam logic [4:0] LS_LAST     = 5'(LS_DIV - 1);
    localparam logic [1:0] HOLD_RELOAD = 2'(HOLD_BITS);

    // FIFO storage: each entry is {drive enable, D+, D-}
    logic [2:0] r_fifo [0:3];
    logic [2:0] r_count;
    logic [1:0] r_inIdx;
    logic [1:0] r_outIdx;

    logic [4:0] r_div;
    logic       r_rateQ;

    logic [1:0] r_bitsOut;
    logic       r_ctrlOut;
    logic       r_active;
    logic       r_tickOut;
    logic [1:0] r_hold;

    logic [4:0] w_divLast;
    logic       w_rateChange;
    logic       w_tick;
    logic       w_push;
    logic       w_pop;
    logic [2:0] w_popEntry;
    logic       w_loadCtrl;

    assign w_divLast    = fullSpeedRate ? FS_LAST : LS_LAST;
    assign w_rateChange = (r_rateQ != fullSpeedRate);
    assign w_tick       = (r_div == w_divLast);

    assign SIETxRdy   = (r_count != 3'd4);
    assign w_push     = SIETxWEn && SIETxRdy;
    // An empty FIFO at a tick is an underrun: nothing is popped and the wire is released.
    assign w_pop      = w_tick && (r_count != 3'd0);
    assign w_popEntry = r_fifo[r_outIdx];
    assign w_loadCtrl = w_pop && w_popEntry[2];

    assign TxBitsOut         = r_bitsOut;
    assign TxCtrlOut         = r_ctrlOut;
    assign TxWireActiveDrive = r_active;
    assign TxDataOutTick     = r_tickOut;

    // Bit-period divider. The rate register follows the input even during
    // reset so that leaving reset never looks like a rate change; a real rate
    // change restarts the bit period from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div   <= 5'd0;
            r_rateQ <= fullSpeedRate;
        end else begin
            r_rateQ <= fullSpeedRate;
            if (w_rateChange || w_tick) begin
                r_div <= 5'd0;
            end else begin
                r_div <= r_div + 5'd1;
            end
        end
    end

    // FIFO storage. Reset only needs to clear the indices and count, so the
    // memory itself is left unreset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_inIdx] <= {TxCtrlIn, TxBitsIn};
        end
    end

    // FIFO bookkeeping: indices wrap naturally at 2 bits, and a push and pop
    // in the same cycle leave the occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= 3'd0;
            r_inIdx  <= 2'd0;
            r_outIdx <= 2'd0;
        end else begin
            if (w_push) begin
                r_inIdx <= r_inIdx + 2'd1;
            end
            if (w_pop) begin
                r_outIdx <= r_outIdx + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Pad outputs and receive-blanking flag, all updated only on a bit tick.
    // The hold counter only counts down on ticks where the wire was already
    // released during the previous bit period, so the blanking flag drops
    // HOLD_BITS bit periods after the release itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bitsOut <= 2'b00;
            r_ctrlOut <= 1'b0;
            r_active  <= 1'b0;
            r_tickOut <= 1'b0;
            r_hold    <= 2'd0;
        end else if (w_tick) begin
            r_tickOut <= ~r_tickOut;
            if (w_pop) begin
                r_bitsOut <= w_popEntry[1:0];
                r_ctrlOut <= w_popEntry[2];
            end else begin
                r_ctrlOut <= 1'b0;
            end
            if (w_loadCtrl) begin
                r_hold   <= HOLD_RELOAD;
                r_active <= 1'b1;
            end else if (!r_ctrlOut && (r_hold != 2'd0)) begin
                r_hold <= r_hold - 2'd1;
                if (r_hold == 2'd1) begin
                    r_active <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_wire_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_usb_wire_tx_serializer
//
// Bench for usb_wire_tx_serializer. A reference model follows the inputs at
// each rising edge: the FIFO is a queue, bit periods come from cycle
// arithmetic relative to the end of reset, and the blanking flag is derived
// from how many bit periods have passed since the wire was last driven. Each
// modelled bit period pushes the expected pad state into a scoreboard queue,
// which a monitor drains whenever the DUT toggles TxDataOutTick.
// ---------------------------------------------------------------------------
module tb_usb_wire_tx_serializer;

    localparam int HOLD = 2;

    logic       clk;
    logic       rst;
    logic [1:0] TxBitsIn;
    logic       TxCtrlIn;
    logic       SIETxWEn;
    logic       SIETxRdy;
    logic       fullSpeedRate;
    logic [1:0] TxBitsOut;
    logic       TxCtrlOut;
    logic       TxWireActiveDrive;
    logic       TxDataOutTick;

    usb_wire_tx_serializer dut (
        .clk               (clk),
        .rst               (rst),
        .TxBitsIn          (TxBitsIn),
        .TxCtrlIn          (TxCtrlIn),
        .SIETxWEn          (SIETxWEn),
        .SIETxRdy          (SIETxRdy),
        .fullSpeedRate     (fullSpeedRate),
        .TxBitsOut         (TxBitsOut),
        .TxCtrlOut         (TxCtrlOut),
        .TxWireActiveDrive (TxWireActiveDrive),
        .TxDataOutTick     (TxDataOutTick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Model state
    logic [2:0] mq[$];
    logic [3:0] expQ[$];
    int         cyc = 0;
    int         base = 0;
    bit         armed = 0;
    bit         inRst = 0;
    logic       curCtrl = 1'b0;
    logic [1:0] curBits = 2'b00;
    logic       curActive = 1'b0;
    logic       curTick = 1'b0;
    bit         everDriven = 0;
    int         sinceDrive = 0;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic reportTimeout(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s at t=%0t: got timeout expected event", name, $time);
    endtask

    // True when the coming rising edge falls in the last cycle of a bit period
    function automatic bit tickNext();
        int d;
        d = fullSpeedRate ? 4 : 32;
        return ((cyc - base) % d) == (d - 1);
    endfunction

    // Reference model: evaluated on every rising edge using the inputs that
    // were stable before it.
    initial begin
        int         d;
        bit         tk;
        bit         full;
        bit         doPush;
        logic [2:0] e;
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                expQ.delete();
                curCtrl    = 1'b0;
                curBits    = 2'b00;
                curActive  = 1'b0;
                curTick    = 1'b0;
                everDriven = 0;
                sinceDrive = 0;
                base       = cyc + 1;
                inRst      = 1;
                armed      = 1;
            end else if (armed) begin
                inRst  = 0;
                d      = fullSpeedRate ? 4 : 32;
                tk     = ((cyc - base) % d) == (d - 1);
                full   = (mq.size() == 4);
                doPush = SIETxWEn && !full;
                if (tk) begin
                    if (mq.size() > 0) begin
                        e       = mq.pop_front();
                        curCtrl = e[2];
                        curBits = e[1:0];
                    end else begin
                        curCtrl = 1'b0;
                    end
                    curTick = ~curTick;
                    if (curCtrl) begin
                        everDriven = 1;
                        sinceDrive = 0;
                    end else if (everDriven && sinceDrive < 1000) begin
                        sinceDrive++;
                    end
                    curActive = everDriven && (sinceDrive <= HOLD);
                    expQ.push_back({curCtrl, curBits, curActive});
                end
                if (doPush) begin
                    mq.push_back({TxCtrlIn, TxBitsIn});
                end
            end
            cyc++;
        end
    end

    // Monitor: samples on the falling edge, drains the scoreboard on each
    // DUT bit-period toggle and checks held state and ready every cycle.
    initial begin
        logic       prevTick;
        logic       toggled;
        logic       expRdy;
        logic [3:0] e;
        prevTick = 1'b0;
        forever begin
            @(negedge clk);
            if (armed) begin
                toggled = (TxDataOutTick !== prevTick);
                if (!inRst) begin
                    if (expQ.size() > 0) begin
                        e = expQ.pop_front();
                        checkOutput("tick_seen", {7'd0, toggled}, 8'd1);
                        checkOutput("tick_entry", {4'd0, TxCtrlOut, TxBitsOut, TxWireActiveDrive}, {4'd0, e});
                    end else begin
                        checkOutput("no_tick", {7'd0, toggled}, 8'd0);
                    end
                end
                checkOutput("hold_state",
                            {3'd0, TxCtrlOut, TxBitsOut, TxWireActiveDrive, TxDataOutTick},
                            {3'd0, curCtrl, curBits, curActive, curTick});
                expRdy = (mq.size() != 4);
                checkOutput("rdy", {7'd0, SIETxRdy}, {7'd0, expRdy});
            end
            prevTick = TxDataOutTick;
        end
    end

    task automatic applyStimulus(input logic we, input logic ctrl, input logic [1:0] bits);
        @(negedge clk);
        SIETxWEn = we;
        TxCtrlIn = ctrl;
        TxBitsIn = bits;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 2'b00);
    endtask

    task automatic doReset(input int n, input logic rate, input logic weDuring);
        @(negedge clk);
        rst           = 1'b1;
        fullSpeedRate = rate;
        SIETxWEn      = weDuring;
        TxCtrlIn      = 1'b1;
        TxBitsIn      = 2'b11;
        repeat (n) @(negedge clk);
        rst      = 1'b0;
        SIETxWEn = 1'b0;
    endtask

    // Leaves the bench at the falling edge just before a tick cycle in which
    // the FIFO holds n entries, then drives a write into that tick cycle.
    task automatic writeInTick(input int n, input string name);
        bit found;
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            SIETxWEn = 1'b0;
            if (tickNext() && mq.size() == n) found = 1;
        end
        if (!found) begin
            reportTimeout(name);
        end else begin
            SIETxWEn = 1'b1;
            TxCtrlIn = 1'b1;
            TxBitsIn = 2'(n);
        end
    endtask

    initial begin
        bit   found;
        int   k;
        logic rate;
        int   prob;
        int   n;

        rst           = 1'b0;
        SIETxWEn      = 1'b0;
        TxCtrlIn      = 1'b0;
        TxBitsIn      = 2'b00;
        fullSpeedRate = 1'b1;

        // Reset with the write strobe held high
        doReset(3, 1'b1, 1'b1);
        idle(8);

        // Full-speed single driven entry, then release
        applyStimulus(1'b1, 1'b1, 2'b10);
        idle(30);

        // Low-speed: five back-to-back writes, the fifth must be dropped
        doReset(2, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 2'($urandom_range(0, 3)));
        idle(6 * 32 + 10);

        // Low-speed stream of eight entries, written whenever there is room
        k = 0;
        for (int i = 0; i < 20 * 32 && k < 8; i++) begin
            @(negedge clk);
            if (mq.size() < 4) begin
                SIETxWEn = 1'b1;
                TxCtrlIn = 1'b1;
                TxBitsIn = 2'($urandom_range(0, 3));
                k++;
            end else begin
                SIETxWEn = 1'b0;
            end
        end
        if (k < 8) reportTimeout("ls_stream_fill");
        idle(12 * 32);

        // Write attempts landing in the tick cycle, at full and at three entries
        doReset(2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 2'(i));
        writeInTick(4, "tick_write_full");
        idle(1);
        writeInTick(3, "tick_write_three");
        idle(7 * 32);

        // Full-speed reset in the middle of a four-entry burst
        doReset(2, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 2'(3 - i));
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            SIETxWEn = 1'b0;
            if (mq.size() <= 2) found = 1;
        end
        if (!found) reportTimeout("midpacket_wait");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(40);

        // Randomized phases at both rates and varying write densities
        for (int p = 0; p < 8; p++) begin
            rate = 1'($urandom_range(0, 1));
            prob = $urandom_range(10, 90);
            doReset($urandom_range(1, 3), rate, 1'($urandom_range(0, 1)));
            n = rate ? 300 : 900;
            for (int i = 0; i < n; i++) begin
                applyStimulus($urandom_range(0, 99) < prob,
                              $urandom_range(0, 7) != 0,
                              2'($urandom_range(0, 3)));
            end
            idle(rate ? 30 : 200);
        end

        idle(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
